// File: rtl/terminal_pkg.sv
// Shared constants and types for the 80x30 text terminal byte-stream sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a; TERMINAL_COLOR_EN selects whether colour codes are honoured.
package terminal_pkg;

  localparam int DEFAULT_COLUMNS = 80;
  localparam int DEFAULT_ROWS    = 30;

  localparam logic [7:0] CODE_NUL       = 8'h00;
  localparam logic [7:0] CODE_BACKSPACE = 8'h08;
  localparam logic [7:0] CODE_LF        = 8'h0A;
  localparam logic [7:0] CODE_FF        = 8'h0C;
  localparam logic [7:0] CODE_CR        = 8'h0D;
  localparam logic [7:0] CODE_HOME      = 8'h1B;

  localparam logic [2:0] DEFAULT_COLOR = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } term_state_e;

  // Bytes 0x01..0x07 select an RGB attribute rather than printing.
  function automatic logic is_color_code(input logic [7:0] b);
    return (b >= 8'h01) && (b <= 8'h07);
  endfunction

endpackage

// File: rtl/text_terminal_controller.sv
// Byte-stream sequencer: UART bytes -> cursor moves and character RAM writes; TERMINAL_COLOR_EN enables colour codes.
// Latency: 1 cycle from byte acceptance to registered RAM write; cursor updates at the accepting edge.
// Backpressure: Ready_o drops for the duration of a form-feed screen clear (one blank write per cycle).
module text_terminal_controller
  import terminal_pkg::*;
#(
  parameter int         COLUMNS       = DEFAULT_COLUMNS,
  parameter int         ROWS          = DEFAULT_ROWS,
  parameter int         ADDRESS_WIDTH = 12,
  parameter logic [7:0] BLANK_CHAR    = 8'h20
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [7:0]               Data_i,
  input  logic                     DataValid_i,
  output logic                     Ready_o,
  output logic                     WriteEnable_o,
  output logic [ADDRESS_WIDTH-1:0] WriteAddress_o,
  output logic [7:0]               WriteData_o,
  output logic [2:0]               WriteColor_o,
  output logic [6:0]               CursorX_o,
  output logic [4:0]               CursorY_o
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(COLUMNS * ROWS - 1);
  localparam logic [6:0]               LAST_X    = 7'(COLUMNS - 1);
  localparam logic [4:0]               LAST_Y    = 5'(ROWS - 1);

  term_state_e              state_q, state_d;
  logic [6:0]               cur_x_q, cur_x_d;
  logic [4:0]               cur_y_q, cur_y_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]               wr_data_q, wr_data_d;
  logic [6:0]               bk_x;
  logic [4:0]               bk_y;
  logic                     accept;

`ifdef TERMINAL_COLOR_EN
  logic [2:0]               color_q, color_d;
  logic [2:0]               wr_color_q, wr_color_d;
`endif

  // Linear cell address, computed at the RAM address width.
  function automatic logic [ADDRESS_WIDTH-1:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
    return ADDRESS_WIDTH'(y) * ADDRESS_WIDTH'(COLUMNS) + ADDRESS_WIDTH'(x);
  endfunction

  assign Ready_o = (state_q == ST_IDLE);
  assign accept  = DataValid_i && Ready_o;

  // Next-state, cursor and write-port decode for both states.
  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    clr_cnt_d = clr_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bk_x      = cur_x_q;
    bk_y      = cur_y_q;
`ifdef TERMINAL_COLOR_EN
    color_d   = color_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (Data_i)
            CODE_NUL: begin
              // Padding byte: nothing to do.
            end
            CODE_BACKSPACE: begin
              // The home cell is a hard stop: no move and no blank written.
              if ((cur_x_q != 7'd0) || (cur_y_q != 5'd0)) begin
                if (cur_x_q == 7'd0) begin
                  bk_x = LAST_X;
                  bk_y = cur_y_q - 5'd1;
                end else begin
                  bk_x = cur_x_q - 7'd1;
                  bk_y = cur_y_q;
                end
                cur_x_d   = bk_x;
                cur_y_d   = bk_y;
                wr_en_d   = 1'b1;
                wr_addr_d = cell_addr(bk_x, bk_y);
                wr_data_d = BLANK_CHAR;
              end
            end
            CODE_LF: begin
              // No scrolling: the cursor simply wraps to the top row.
              cur_y_d = (cur_y_q == LAST_Y) ? 5'd0 : cur_y_q + 5'd1;
            end
            CODE_CR: begin
              cur_x_d = 7'd0;
            end
            CODE_FF: begin
              // Cell 0 is emitted on the accepting edge; the counter then covers the rest.
              state_d   = ST_CLEAR;
              cur_x_d   = 7'd0;
              cur_y_d   = 5'd0;
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = BLANK_CHAR;
              clr_cnt_d = ADDRESS_WIDTH'(1);
            end
            CODE_HOME: begin
              cur_x_d = 7'd0;
              cur_y_d = 5'd0;
            end
            default: begin
              if (is_color_code(Data_i)) begin
`ifdef TERMINAL_COLOR_EN
                color_d = Data_i[2:0];
`endif
              end else begin
                // Printable: write at the pre-advance cursor, then advance with wrap.
                wr_en_d   = 1'b1;
                wr_addr_d = cell_addr(cur_x_q, cur_y_q);
                wr_data_d = Data_i;
                if (cur_x_q == LAST_X) begin
                  cur_x_d = 7'd0;
                  cur_y_d = (cur_y_q == LAST_Y) ? 5'd0 : cur_y_q + 5'd1;
                end else begin
                  cur_x_d = cur_x_q + 7'd1;
                end
              end
            end
          endcase
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = BLANK_CHAR;
        if (clr_cnt_q == LAST_ADDR) begin
          // Leaving on the last emitted cell lets a byte be accepted during that write.
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDRESS_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef TERMINAL_COLOR_EN
  // Every write, clear and backspace included, carries the current colour.
  always_comb begin
    wr_color_d = wr_en_d ? color_q : wr_color_q;
  end
`endif

  // State, cursor, clear counter and registered write port.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cur_x_q   <= 7'd0;
      cur_y_q   <= 5'd0;
      clr_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      clr_cnt_q <= clr_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef TERMINAL_COLOR_EN
  // Colour register and the colour latched alongside each write.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      color_q    <= DEFAULT_COLOR;
      wr_color_q <= DEFAULT_COLOR;
    end else begin
      color_q    <= color_d;
      wr_color_q <= wr_color_d;
    end
  end

  assign WriteColor_o = wr_color_q;
`else
  assign WriteColor_o = DEFAULT_COLOR;
`endif

  assign WriteEnable_o  = wr_en_q;
  assign WriteAddress_o = wr_addr_q;
  assign WriteData_o    = wr_data_q;
  assign CursorX_o      = cur_x_q;
  assign CursorY_o      = cur_y_q;

endmodule

// File: tb/tb_text_terminal_controller.sv
// Self-checking bench for text_terminal_controller: directed scenarios plus randomized bytes vs a linear-position model.
// Latency: model predicts each cycle's write port, ready and cursor one edge ahead.
// Backpressure: model tracks the clear sweep and ignores bytes offered while it runs; honours TERMINAL_COLOR_EN.
module tb_text_terminal_controller;

  localparam int NCOL  = 80;
  localparam int NROW  = 30;
  localparam int NCELL = NCOL * NROW;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  Data_i;
  logic        DataValid_i;
  logic        Ready_o;
  logic        WriteEnable_o;
  logic [11:0] WriteAddress_o;
  logic [7:0]  WriteData_o;
  logic [2:0]  WriteColor_o;
  logic [6:0]  CursorX_o;
  logic [4:0]  CursorY_o;

  text_terminal_controller dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Data_i         (Data_i),
    .DataValid_i    (DataValid_i),
    .Ready_o        (Ready_o),
    .WriteEnable_o  (WriteEnable_o),
    .WriteAddress_o (WriteAddress_o),
    .WriteData_o    (WriteData_o),
    .WriteColor_o   (WriteColor_o),
    .CursorX_o      (CursorX_o),
    .CursorY_o      (CursorY_o)
  );

  always #5 Clock = ~Clock;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: cursor as a linear cell index, clear as "next cell to blank" (-1 when idle).
  int m_pos, m_color, m_clr;
  int e_we, e_addr, e_data, e_color;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_color = 7; m_clr = -1;
    e_we = 0; e_addr = 0; e_data = 0; e_color = 7;
  endtask

  task automatic put(input int addr, input int data);
    e_we = 1; e_addr = addr; e_data = data; e_color = m_color;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] b);
    e_we = 0;
    if (m_clr >= 0) begin
      put(m_clr, 8'h20);
      m_clr = (m_clr == NCELL - 1) ? -1 : m_clr + 1;
    end else if (v) begin
      if (b == 8'h00) begin
      end else if (b >= 8'h01 && b <= 8'h07) begin
`ifdef TERMINAL_COLOR_EN
        m_color = int'(b[2:0]);
`endif
      end else if (b == 8'h08) begin
        if (m_pos != 0) begin
          m_pos = m_pos - 1;
          put(m_pos, 8'h20);
        end
      end else if (b == 8'h0A) begin
        m_pos = (((m_pos / NCOL) + 1) % NROW) * NCOL + (m_pos % NCOL);
      end else if (b == 8'h0D) begin
        m_pos = m_pos - (m_pos % NCOL);
      end else if (b == 8'h0C) begin
        m_pos = 0;
        put(0, 8'h20);
        m_clr = 1;
      end else if (b == 8'h1B) begin
        m_pos = 0;
      end else begin
        put(m_pos, int'(b));
        m_pos = (m_pos + 1) % NCELL;
      end
    end
  endtask

  task automatic check_outputs();
    chk("ready", Ready_o, (m_clr < 0) ? 1 : 0);
    chk("we", WriteEnable_o, e_we);
    if (e_we != 0) begin
      chk("addr", WriteAddress_o, e_addr);
      chk("data", WriteData_o, e_data);
      chk("color", WriteColor_o, e_color);
    end
    chk("cur_x", CursorX_o, m_pos % NCOL);
    chk("cur_y", CursorY_o, m_pos / NCOL);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, Ready_o, 1);
    chk({tag, "_we"}, WriteEnable_o, 0);
    chk({tag, "_addr"}, WriteAddress_o, 0);
    chk({tag, "_data"}, WriteData_o, 0);
    chk({tag, "_color"}, WriteColor_o, 7);
    chk({tag, "_x"}, CursorX_o, 0);
    chk({tag, "_y"}, CursorY_o, 0);
  endtask

  // Called at a falling edge: check this cycle, drive, clock, update model.
  task automatic step(input logic v, input logic [7:0] b);
    check_outputs();
    DataValid_i = v;
    Data_i      = b;
    @(posedge Clock);
    model_edge(v, b);
    @(negedge Clock);
  endtask

  initial begin
    int lowcnt;
    int guard;
    int r;
    int ff_budget;
    logic [7:0] b;
    logic v;

    Reset = 1'b0; DataValid_i = 1'b0; Data_i = 8'h00;
    model_reset();
    repeat (2) @(negedge Clock);
    check_reset_values("rst");
    Reset = 1'b1;

    // "A","B" back to back.
    step(1'b1, 8'h41);
    step(1'b1, 8'h42);
    step(1'b0, 8'h00);
    chk("ab_x", CursorX_o, 2);
    chk("ab_y", CursorY_o, 0);

    // Last cell wraps to home.
    step(1'b1, 8'h1B);
    for (int i = 0; i < 29; i++) step(1'b1, 8'h0A);
    for (int i = 0; i < 79; i++) step(1'b1, 8'(8'h61 + (i % 26)));
    chk("corner_x", CursorX_o, 79);
    chk("corner_y", CursorY_o, 29);
    step(1'b1, 8'h5A);
    chk("wrap_we", WriteEnable_o, 1);
    chk("wrap_addr", WriteAddress_o, 2399);
    chk("wrap_data", WriteData_o, 8'h5A);
    chk("wrap_x", CursorX_o, 0);
    chk("wrap_y", CursorY_o, 0);

    // Backspace across a row boundary, then at home.
    step(1'b1, 8'h0A);
    step(1'b1, 8'h08);
    chk("bs_we", WriteEnable_o, 1);
    chk("bs_addr", WriteAddress_o, 79);
    chk("bs_data", WriteData_o, 8'h20);
    chk("bs_x", CursorX_o, 79);
    chk("bs_y", CursorY_o, 0);
    step(1'b1, 8'h1B);
    step(1'b1, 8'h08);
    chk("bs_home_we", WriteEnable_o, 0);

    // Colour code then a character.
    step(1'b1, 8'h04);
    chk("colcode_we", WriteEnable_o, 0);
    step(1'b1, 8'h58);
    chk("col_we", WriteEnable_o, 1);
`ifdef TERMINAL_COLOR_EN
    chk("col_color", WriteColor_o, 3'b100);
`else
    chk("col_color", WriteColor_o, 3'b111);
`endif

    // Form feed with a byte held valid throughout the clear.
    step(1'b1, 8'h0C);
    lowcnt = 0;
    while (Ready_o !== 1'b1 && lowcnt < 3000) begin
      lowcnt++;
      step(1'b1, 8'h51);
    end
    chk("ff_ready_low_cycles", lowcnt, 2399);
    chk("ff_last_addr", WriteAddress_o, 2399);
    step(1'b1, 8'h51);
    chk("ff_next_we", WriteEnable_o, 1);
    chk("ff_next_addr", WriteAddress_o, 0);
    chk("ff_next_data", WriteData_o, 8'h51);

    // Reset in the middle of a clear.
    step(1'b1, 8'h0C);
    guard = 0;
    while (!(e_we != 0 && e_addr == 1000) && guard < 3000) begin
      guard++;
      step(1'b0, 8'h00);
    end
    chk("midclr_reached", WriteAddress_o, 1000);
    Reset = 1'b0;
    #1;
    check_reset_values("midclr");
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
    chk("post_rst_ready", Ready_o, 1);

    // Randomized traffic.
    ff_budget = 2;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(32, 126));
      else if (r < 70) b = 8'($urandom_range(1, 7));
      else if (r < 76) b = 8'h08;
      else if (r < 82) b = 8'h0A;
      else if (r < 86) b = 8'h0D;
      else if (r < 89) b = 8'h1B;
      else if (r < 92) b = 8'h00;
      else if (r == 92 && ff_budget > 0) begin
        b = 8'h0C;
        ff_budget--;
      end else b = 8'($urandom_range(32, 126));
      v = ($urandom_range(0, 3) != 0);
      step(v, b);
    end
    step(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
